// File: rtl/pzcorebus_upsizer_pkg.sv
// Shared definitions for the pzcorebus upsizer (write packer, response unpacker).
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package pzcorebus_upsizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } upsizer_state_e;

  // Number of narrow lanes in one wide word.
  function automatic int calc_ratio(int slave_width, int master_width);
    return master_width / slave_width;
  endfunction

  // Width of a lane index; never below 1 so that port widths stay legal.
  function automatic int calc_lane_width(int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/pzcorebus_upsizer_write_packer.sv
// Packs narrow write-data beats into wide beats, one burst descriptor at a time.
// Latency: o_data_valid rises the cycle after the narrow beat that completes a word.
// Backpressure: o_data_ready = !o_data_valid || i_data_ready in PACK; 0 in IDLE/DRAIN.
//
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_cmd_valid/o_cmd_ready             descriptor handshake (offset = start lane,
//   i_cmd_offset, i_cmd_length          length in narrow beats, 0 = 2**LENGTH_WIDTH)
//   i_data_valid/o_data_ready           narrow beat handshake with i_data, i_byteen, i_last
//   o_data_valid/i_data_ready           wide beat handshake with o_data, o_byteen, o_last
//   o_length_error                      pulse when i_last disagrees with the descriptor
//   o_busy                              burst in progress
module pzcorebus_upsizer_write_packer
  import pzcorebus_upsizer_pkg::*;
#(
  parameter int SLAVE_DATA_WIDTH  = 32,
  parameter int MASTER_DATA_WIDTH = 128,
  parameter int LENGTH_WIDTH      = 8,
  localparam int RATIO  = calc_ratio(SLAVE_DATA_WIDTH, MASTER_DATA_WIDTH),
  localparam int LANE_W = calc_lane_width(RATIO)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_cmd_valid,
  output logic                           o_cmd_ready,
  input  logic [LANE_W-1:0]              i_cmd_offset,
  input  logic [LENGTH_WIDTH-1:0]        i_cmd_length,
  input  logic                           i_data_valid,
  output logic                           o_data_ready,
  input  logic [SLAVE_DATA_WIDTH-1:0]    i_data,
  input  logic [SLAVE_DATA_WIDTH/8-1:0]  i_byteen,
  input  logic                           i_last,
  output logic                           o_data_valid,
  input  logic                           i_data_ready,
  output logic [MASTER_DATA_WIDTH-1:0]   o_data,
  output logic [MASTER_DATA_WIDTH/8-1:0] o_byteen,
  output logic                           o_last,
  output logic                           o_length_error,
  output logic                           o_busy
);

  localparam int SBE_W = SLAVE_DATA_WIDTH / 8;
  localparam int MBE_W = MASTER_DATA_WIDTH / 8;
  // One extra bit so a zero length field can be held as 2**LENGTH_WIDTH.
  localparam int CNT_W = LENGTH_WIDTH + 1;

  if (RATIO < 2 || (RATIO & (RATIO - 1)) != 0 ||
      RATIO * SLAVE_DATA_WIDTH != MASTER_DATA_WIDTH) begin : g_bad_ratio
    $error("pzcorebus_upsizer_write_packer: width ratio must be a power of 2 and >= 2");
  end

  upsizer_state_e state, state_next;

  logic [LANE_W-1:0]            lane;
  logic [CNT_W-1:0]             remaining;
  logic [MASTER_DATA_WIDTH-1:0] acc_data;
  logic [MBE_W-1:0]             acc_byteen;
  logic [MASTER_DATA_WIDTH-1:0] beat_data;
  logic [MBE_W-1:0]             beat_byteen;

  logic cmd_hs;
  logic data_hs;
  logic wide_hs;
  logic rem_one;
  logic is_last;
  logic word_done;

  assign cmd_hs    = i_cmd_valid && o_cmd_ready;
  assign data_hs   = i_data_valid && o_data_ready;
  assign wide_hs   = o_data_valid && i_data_ready;
  assign rem_one   = (remaining == CNT_W'(1));
  assign is_last   = rem_one || i_last;
  assign word_done = (lane == LANE_W'(RATIO - 1)) || is_last;
  assign o_busy    = (state != IDLE);

  // Current accumulator with the incoming narrow beat merged into its lane.
  always_comb begin
    beat_data   = acc_data;
    beat_byteen = acc_byteen;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == LANE_W'(k)) begin
        beat_data[k*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH] = i_data;
        beat_byteen[k*SBE_W +: SBE_W]                     = i_byteen;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    o_cmd_ready  = 1'b0;
    o_data_ready = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          state_next = PACK;
        end
      end
      PACK: begin
        o_data_ready = !o_data_valid || i_data_ready;
        if (data_hs && is_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (wide_hs && o_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane           <= '0;
      remaining      <= '0;
      acc_data       <= '0;
      acc_byteen     <= '0;
      o_data_valid   <= 1'b0;
      o_data         <= '0;
      o_byteen       <= '0;
      o_last         <= 1'b0;
      o_length_error <= 1'b0;
    end else begin
      o_length_error <= 1'b0;
      if (wide_hs) begin
        o_data_valid <= 1'b0;
        o_last       <= 1'b0;
      end
      if (cmd_hs) begin
        lane       <= i_cmd_offset;
        remaining  <= (i_cmd_length == '0) ? {1'b1, {LENGTH_WIDTH{1'b0}}}
                                           : {1'b0, i_cmd_length};
        acc_data   <= '0;
        acc_byteen <= '0;
      end
      if (data_hs) begin
        // Lane counter wraps naturally because RATIO == 2**LANE_W.
        lane      <= lane + LANE_W'(1);
        remaining <= remaining - CNT_W'(1);
        if (word_done) begin
          // A word completing in the same cycle the previous one is taken
          // overrides the valid clear above: zero-bubble hand-over.
          o_data_valid   <= 1'b1;
          o_data         <= beat_data;
          o_byteen       <= beat_byteen;
          o_last         <= is_last;
          o_length_error <= i_last != rem_one;
          acc_data       <= '0;
          acc_byteen     <= '0;
          if (is_last) begin
            // An early i_last abandons whatever the descriptor still promised.
            remaining <= '0;
          end
        end else begin
          acc_data   <= beat_data;
          acc_byteen <= beat_byteen;
        end
      end
    end
  end

endmodule

// File: tb/tb_pzcorebus_upsizer_write_packer.sv
// Bench for the write packer: directed bursts plus randomized bursts against a queue model.
// Latency: n/a.
// Backpressure: randomized narrow-side gaps and wide-side ready.
module tb_pzcorebus_upsizer_write_packer;

  localparam int SW  = 32;
  localparam int MW  = 128;
  localparam int R   = MW / SW;
  localparam int LW  = 8;
  localparam int BW  = SW / 8;
  localparam int MBW = MW / 8;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic           i_cmd_valid;
  logic           o_cmd_ready;
  logic [1:0]     i_cmd_offset;
  logic [LW-1:0]  i_cmd_length;
  logic           i_data_valid;
  logic           o_data_ready;
  logic [SW-1:0]  i_data;
  logic [BW-1:0]  i_byteen;
  logic           i_last;
  logic           o_data_valid;
  logic           i_data_ready = 1'b0;
  logic [MW-1:0]  o_data;
  logic [MBW-1:0] o_byteen;
  logic           o_last;
  logic           o_length_error;
  logic           o_busy;

  always #5 i_clk = ~i_clk;

  pzcorebus_upsizer_write_packer #(
    .SLAVE_DATA_WIDTH (SW),
    .MASTER_DATA_WIDTH(MW),
    .LENGTH_WIDTH     (LW)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_offset  (i_cmd_offset),
    .i_cmd_length  (i_cmd_length),
    .i_data_valid  (i_data_valid),
    .o_data_ready  (o_data_ready),
    .i_data        (i_data),
    .i_byteen      (i_byteen),
    .i_last        (i_last),
    .o_data_valid  (o_data_valid),
    .i_data_ready  (i_data_ready),
    .o_data        (o_data),
    .o_byteen      (o_byteen),
    .o_last        (o_last),
    .o_length_error(o_length_error),
    .o_busy        (o_busy)
  );

  typedef struct packed {
    logic [MW-1:0]  d;
    logic [MBW-1:0] be;
    logic           last;
  } wbeat_t;

  wbeat_t exp_q[$];
  int n_vec     = 0;
  int n_err     = 0;
  int err_cnt   = 0;
  int ready_pct = 100;
  int gap_pct   = 0;

  localparam logic [150:0] RESET_VEC = {1'b1, 1'b0, 1'b0, 128'd0, 16'd0, 1'b0, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wide-side sink: ready is re-randomized every cycle.
  always @(posedge i_clk) begin
    #1;
    i_data_ready = ($urandom_range(99) < ready_pct);
  end

  // Wide-side monitor, sampled on the falling edge.
  logic           prev_hold = 1'b0;
  logic           prev_last_hs = 1'b0;
  logic [MW-1:0]  hold_d;
  logic [MBW-1:0] hold_be;
  logic           hold_last;
  always @(negedge i_clk) begin
    wbeat_t w;
    if (i_rst_n) begin
      if (prev_last_hs)
        check("cmd_ready_after_last", {o_cmd_ready, o_busy}, 2'b10);
      if (o_length_error) begin
        err_cnt++;
        check("error_on_valid_rise", {o_data_valid, prev_hold}, 2'b10);
      end
      if (prev_hold)
        check("hold_stable", {o_data, o_byteen, o_last}, {hold_d, hold_be, hold_last});
      if (o_data_valid && i_data_ready) begin
        check("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("wide_data", o_data, w.d);
          check("wide_byteen", o_byteen, w.be);
          check("wide_last", o_last, w.last);
        end
      end
      prev_hold    = o_data_valid && !i_data_ready;
      hold_d       = o_data;
      hold_be      = o_byteen;
      hold_last    = o_last;
      prev_last_hs = o_data_valid && i_data_ready && o_last;
    end else begin
      prev_hold    = 1'b0;
      prev_last_hs = 1'b0;
    end
  end

  task automatic send_cmd(input int off, input int len);
    int t;
    i_cmd_valid  = 1'b1;
    i_cmd_offset = 2'(off);
    i_cmd_length = LW'(len);
    @(negedge i_clk);
    t = 0;
    while (!o_cmd_ready && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    check("cmd_accept", o_cmd_ready, 1'b1);
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [SW-1:0] d, input logic [BW-1:0] be, input logic last);
    int t;
    while ($urandom_range(99) < gap_pct) begin
      @(posedge i_clk);
      #1;
    end
    i_data_valid = 1'b1;
    i_data       = d;
    i_byteen     = be;
    i_last       = last;
    @(negedge i_clk);
    t = 0;
    while (!o_data_ready && t < 1000) begin
      @(negedge i_clk);
      t++;
    end
    check("beat_accept", o_data_ready, 1'b1);
    @(posedge i_clk);
    #1;
    i_data_valid = 1'b0;
    i_last       = 1'b0;
  endtask

  // Model: narrow beat i lands in lane (off+i) mod R; a word closes at lane R-1
  // or on the final beat of the burst; unwritten lanes read as zero.
  // base < 0 selects random data/byteen, otherwise data = base+i with full byteen.
  task automatic run_burst(input int off, input int len, input int last_at, input int base);
    int eff, n, lane, t;
    logic [SW-1:0] d[];
    logic [BW-1:0] be[];
    wbeat_t w;
    eff = (len == 0) ? (1 << LW) : len;
    n   = (last_at < eff) ? last_at : eff;
    d   = new[n];
    be  = new[n];
    for (int i = 0; i < n; i++) begin
      d[i]  = (base < 0) ? SW'($urandom) : SW'(base + i);
      be[i] = (base < 0) ? BW'($urandom_range(15)) : {BW{1'b1}};
    end
    w    = '0;
    lane = off;
    for (int i = 0; i < n; i++) begin
      w.d[lane*SW +: SW] = d[i];
      w.be[lane*BW +: BW] = be[i];
      if (lane == R - 1 || i == n - 1) begin
        w.last = (i == n - 1);
        exp_q.push_back(w);
        w = '0;
      end
      lane = (lane + 1) % R;
    end
    err_cnt = 0;
    send_cmd(off, len);
    for (int i = 0; i < n; i++)
      send_beat(d[i], be[i], i == last_at - 1);
    t = 0;
    while ((exp_q.size() != 0 || o_busy) && t < 2000) begin
      @(posedge i_clk);
      #1;
      t++;
    end
    check("beats_drained", exp_q.size(), 0);
    check("length_error_count", err_cnt, (last_at != eff) ? 1 : 0);
    check("busy_clear", o_busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, off, len, eff, last_at;
    logic [MW-1:0] first_d;
    i_rst_n      = 1'b0;
    i_cmd_valid  = 1'b0;
    i_cmd_offset = '0;
    i_cmd_length = '0;
    i_data_valid = 1'b0;
    i_data       = '0;
    i_byteen     = '0;
    i_last       = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("reset_state", {o_cmd_ready, o_data_ready, o_data_valid, o_data, o_byteen,
                          o_last, o_length_error, o_busy}, RESET_VEC);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Aligned full word, unaligned span, single beat at lane wrap, early last.
    run_burst(0, 4, 4, 'hA0);
    run_burst(2, 4, 4, 'hB0);
    run_burst(3, 1, 1, 'hC);
    run_burst(0, 4, 2, 'hD0);
    // Late last: descriptor runs out first.
    run_burst(1, 3, 5, -1);

    // Wide-side stall after the first word, then zero-bubble resume.
    ready_pct = 0;
    fork
      run_burst(0, 8, 8, -1);
      begin
        t = 0;
        do begin
          @(negedge i_clk);
          t++;
        end while (!o_data_valid && t < 200);
        check("bp_first_word", o_data_valid, 1'b1);
        first_d = o_data;
        repeat (5) begin
          @(negedge i_clk);
          check("bp_ready_low", {o_data_ready, o_data_valid}, 2'b01);
          check("bp_data_stable", o_data, first_d);
        end
        ready_pct = 100;
        @(negedge i_clk);
        check("bp_resume", o_data_ready, 1'b1);
      end
    join

    // Reset in the middle of a burst discards the partial word.
    send_cmd(0, 4);
    send_beat(32'h1111_1111, 4'hF, 1'b0);
    send_beat(32'h2222_2222, 4'hF, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("reset_mid_burst", {o_cmd_ready, o_data_ready, o_data_valid, o_data, o_byteen,
                              o_last, o_length_error, o_busy}, RESET_VEC);
    exp_q.delete();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_burst(2, 2, 2, 'hE0);

    // Length field 0 means the maximum burst.
    run_burst(1, 0, 1 << LW, -1);

    // Randomized bursts with gaps and wide-side backpressure.
    gap_pct   = 30;
    ready_pct = 60;
    for (int b = 0; b < 40; b++) begin
      off = $urandom_range(R - 1);
      len = $urandom_range(12, 1);
      eff = len;
      last_at = ($urandom_range(99) < 70) ? eff : $urandom_range(eff + 2, 1);
      run_burst(off, len, last_at, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pzcorebus_upsizer_write_packer.md
Name: pzcorebus_upsizer_write_packer

Overview:
- Write-data width-up converter for pzcorebus.
- Packs narrow write-data beats (SLAVE_DATA_WIDTH) from an upstream agent into wide beats (MASTER_DATA_WIDTH) for a wide downstream bus. It is the packing counterpart of the downsizer's split path.
- Takes one command descriptor (start lane, length in narrow beats) per burst, then accumulates lanes into a single output holding register with valid/ready handshakes on both sides.
- Sits between the command/data aligner and the master-side FIFO of the future upsizer top.

Parameters:
- SLAVE_DATA_WIDTH, 32, narrow data width; multiple of 8.
- MASTER_DATA_WIDTH, 128, wide data width; RATIO = MASTER_DATA_WIDTH/SLAVE_DATA_WIDTH is a power of 2, >= 2.
- LENGTH_WIDTH, 8, width of the burst length field in narrow beats.

Ports:
- i_clk  input  1  clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_cmd_valid  input  1  burst descriptor valid.
- o_cmd_ready  output  1  descriptor accepted when both i_cmd_valid and o_cmd_ready are 1.
- i_cmd_offset  input  log2(RATIO)  starting lane (address bits of the narrow word inside the wide word).
- i_cmd_length  input  LENGTH_WIDTH  narrow beats in the burst; 0 means 2**LENGTH_WIDTH.
- i_data_valid  input  1  narrow beat valid.
- o_data_ready  output  1  narrow beat accepted.
- i_data  input  SLAVE_DATA_WIDTH  narrow data.
- i_byteen  input  SLAVE_DATA_WIDTH/8  narrow byte enables.
- i_last  input  1  upstream last marker.
- o_data_valid  output  1  wide beat valid.
- i_data_ready  input  1  wide beat accepted.
- o_data  output  MASTER_DATA_WIDTH  wide data; lane k = bits [k*SLAVE_DATA_WIDTH +: SLAVE_DATA_WIDTH].
- o_byteen  output  MASTER_DATA_WIDTH/8  wide byte enables; unwritten lanes are 0.
- o_last  output  1  final wide beat of the burst.
- o_length_error  output  1  one-cycle pulse when i_last disagrees with the descriptor length.
- o_busy  output  1  burst in progress (state != IDLE).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_cmd_ready=1; o_data_ready=0; o_data_valid=0; o_data=0; o_byteen=0; o_last=0; o_length_error=0; o_busy=0; lane and remaining counters are 0.
- A reset mid-burst discards the partial word and the descriptor.

States:
- IDLE:
  - o_cmd_ready=1.
  - On a command handshake: lane <= offset; remaining <= length (0 maps to 2**LENGTH_WIDTH); accumulator and byteen cleared; go to PACK.
- PACK:
  - o_data_ready = !o_data_valid || i_data_ready.
  - On a narrow handshake, the beat is written into lane `lane` of the accumulator and lane <= lane+1 mod RATIO.
  - remaining decrements by 1 per narrow handshake.
  - A wide beat completes when lane == RATIO-1, remaining == 1, or i_last == 1.
  - On completion the registered output gets o_data_valid=1, o_last=(remaining==1 || i_last), and the accumulator is cleared for the next word.
  - If o_last is set, go to DRAIN.
- DRAIN:
  - o_data_ready=0; o_cmd_ready=0.
  - On the o_last wide handshake, go to IDLE.
  - A new command is accepted one cycle after the last wide handshake (no IDLE bypass).

Timing and handshake rules:
- Latency: o_data_valid rises the cycle after the completing narrow handshake.
- Throughput: 1 narrow beat/cycle. A narrow beat that starts a new word is accepted in the same cycle the previous wide beat is taken.
- o_data, o_byteen and o_last hold stable while o_data_valid=1 and i_data_ready=0.
- i_data_ready may toggle freely. o_data_valid never drops without a handshake.
- Byte enables are taken from i_byteen per lane. Data of lanes with byteen 0 is passed through unchanged; no masking.

Length checking:
- i_last=1 with remaining>1: the word is flushed as last, o_length_error pulses the same cycle o_data_valid rises, and remaining is discarded.
- remaining==1 with i_last=0: o_last is still asserted and o_length_error pulses.
- Offset wrap: a burst starting at lane RATIO-1 completes its first wide word after one narrow beat.

Decomposition:
- pzcorebus_upsizer_pkg holds:
  - the state enum (IDLE, PACK, DRAIN);
  - the function calc_ratio(slave_width, master_width);
  - the lane-index width function.
- The same package is shared with the planned pzcorebus_upsizer_response_unpacker.
- No sub-module: the lane counter, accumulator and FSM fit in one file.
- Elaboration-time assertion checks that RATIO is a power of 2 and >= 2.

Test Plan (SLAVE_DATA_WIDTH=32, MASTER_DATA_WIDTH=128, RATIO=4):
- Aligned full word: cmd offset=0 length=4; beats 0xA0..0xA3 with byteen 0xF, i_last on the 4th → one wide beat with o_data=0x000000A3_000000A2_000000A1_000000A0, o_byteen=0xFFFF, o_last=1, no error.
- Unaligned span: offset=2 length=4; beats B0..B3 → beat1 has lanes 2,3={B1,B0}, o_byteen=0xFF00, o_last=0; beat2 has lanes 0,1={B3,B2}, o_byteen=0x00FF, o_last=1.
- Backpressure: offset=0 length=8, i_data_ready held 0 for 5 cycles after the first word completes → o_data_ready=0 from the next cycle, output stable; resumes with zero bubble; 2 wide beats total.
- Single beat at wrap: offset=3 length=1, data 0xC → o_data lane3=0xC, o_byteen=0xF000, o_last=1; o_cmd_ready returns 1 the cycle after the handshake.
- Early last: offset=0 length=4, i_last on the 2nd beat → wide beat with o_byteen=0x00FF, o_last=1, o_length_error=1 for one cycle; FSM returns to IDLE.
- Reset mid-burst: assert i_rst_n=0 after 2 of 4 beats → all outputs take reset values immediately; a new burst after release produces correct data with no stale lanes.
